csa_acc_seq: RTL and testbench
==============================

CSA_ACC_SEQ -- requirements
Module: csa_acc_seq

Interface
REQ-001 The block SHALL have one clock and reset is synchronous and active-high.
REQ-002 The block SHALL have this port: clk  in  1  rising-edge clock.
REQ-003 The block SHALL have this port: rst  in  1  synchronous active-high reset.
REQ-004 The block SHALL have this port: start  in  1  begin accumulation job; honoured only in IDLE.
REQ-005 The block SHALL have this port: len  in  8  operand count for the job, sampled with start.
REQ-006 The block SHALL have this port: bias  in  16  initial accumulator value, sampled with start.
REQ-007 The block SHALL have this port: in_valid  in  1  operand available.
REQ-008 The block SHALL have this port: in_data  in  16  unsigned operand.
REQ-009 The block SHALL have this port: in_ready  out  1  block accepts operand this cycle.
REQ-010 The block SHALL have this port: out_valid  out  1  result held stable.
REQ-011 The block SHALL have this port: out_ready  in  1  consumer takes result.
REQ-012 The block SHALL have this port: out_sum  out  16  accumulated result.
REQ-013 The block SHALL have this port: out_ovf  out  1  sticky: a carry-out occurred during the job.
REQ-014 The block SHALL have this port: busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-016 In IDLE with start=1, the block SHALL load acc<=bias, ovf<=0 and cnt<=len; next state is ACC if len!=0, else DONE.
REQ-017 in_ready SHALL equal 1 only in ACC; an operand transfers when in_valid&&in_ready.
REQ-018 On transfer, the block SHALL compute {cout,sum} = acc + in_data + 0 through a single csa_16b instance (cin tied 0), register the result into acc in the same cycle, and decrement cnt.
REQ-019 On transfer, ovf SHALL be set if cout=1; ovf is sticky until the next start.
REQ-020 On the transfer with cnt==1, the next state SHALL be DONE; with in_valid low, ACC SHALL hold with no change.
REQ-021 In DONE, out_valid=1, out_sum=acc and out_ovf=ovf SHALL be held stable until out_ready=1; on that cycle the next state is IDLE.
REQ-022 out_valid SHALL be 0 outside DONE; out_sum/out_ovf are don't-care there but SHALL retain the last acc/ovf values.
REQ-023 start outside IDLE SHALL be ignored, including start coincident with the DONE/out_ready cycle.
REQ-024 Latency: len=N with in_valid held high SHALL give out_valid exactly N+1 cycles after the start cycle; len=0 gives out_valid 1 cycle after start with out_sum=bias.
REQ-025 Unsigned arithmetic SHALL wrap modulo 2^16 (macro absent).

Reset
REQ-026 rst=1 SHALL override all inputs, including mid-ACC and mid-DONE.
REQ-027 On rst, state=IDLE, acc=0, ovf=0, cnt=0, in_ready=0, out_valid=0, out_sum=0, out_ovf=0 and busy=0; any in-flight job is discarded.

Configuration
REQ-028 The macro CSA_ACC_SAT_EN SHALL control saturation.
REQ-029 With CSA_ACC_SAT_EN defined, a transfer with cout=1 SHALL load acc<=16'hFFFF, and acc SHALL remain 16'hFFFF for the rest of the job (operands are still consumed); ovf behaves as in REQ-019.
REQ-030 With CSA_ACC_SAT_EN undefined, the wrap behaviour of REQ-025 SHALL apply and no saturation logic SHALL be present.

Structure
REQ-031 Package csa_pkg SHALL hold: DATA_W=16, CNT_W=8, and the state enum typedef (IDLE, ACC, DONE).
REQ-032 The existing csa_16b SHALL be instantiated once as the only sub-module; no other adder SHALL be inferred for acc.
REQ-033 cnt SHALL be CNT_W bits; the decrement SHALL never be applied at 0.

Verification
REQ-034 Scenario: rst, then start len=3 bias=0x0000, operands 0x0001, 0x0002, 0x0003 with in_valid held high -> out_valid 4 cycles after start, out_sum=0x0006, out_ovf=0.
REQ-035 Scenario: start len=2 bias=0xAA55, operands 0x55AA, 0x0002 -> without macro out_sum=0x0001, out_ovf=1; with CSA_ACC_SAT_EN out_sum=0xFFFF, out_ovf=1.
REQ-036 Scenario: start len=0 bias=0x1234 -> out_valid next cycle, out_sum=0x1234, out_ovf=0, in_ready never high.
REQ-037 Scenario: len=2 with in_valid gapped (1,0,0,1) and out_ready low for 3 cycles -> result held stable, a start pulse during DONE is ignored, IDLE after the out_ready cycle.
REQ-038 Scenario: rst asserted after the first of 4 operands -> next cycle busy=0, out_valid=0, out_sum=0; a new job len=1 bias=0xAA05 with operand 0xFF04 gives out_sum=0xA909, out_ovf=1 (macro absent).

Source files
------------

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared widths and FSM state type for the csa_acc_seq accumulator
package csa_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/csa_acc_seq_if.sv
// rtl/csa_acc_seq_if.sv - job/operand/result handshake bundle for csa_acc_seq
interface csa_acc_seq_if;
    import csa_pkg::*;

    logic              start;
    logic [CNT_W-1:0]  len;
    logic [DATA_W-1:0] bias;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovf;
    logic              busy;

    modport master (
        output start, len, bias, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  start, len, bias, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/csa_16b.sv
// rtl/csa_16b.sv - 16-bit carry-select adder: {o_cout,o_sum} = i_a + i_b + i_cin
module csa_16b
    import csa_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_cin,
    output logic [DATA_W-1:0] o_sum,
    output logic              o_cout
);
    localparam int H = DATA_W / 2;

    logic [H:0] w_lo;
    logic [H:0] w_hi0;
    logic [H:0] w_hi1;

    // Upper half is precomputed for both incoming carries; the low-half carry selects.
    assign w_lo  = {1'b0, i_a[H-1:0]} + {1'b0, i_b[H-1:0]} + {{H{1'b0}}, i_cin};
    assign w_hi0 = {1'b0, i_a[DATA_W-1:H]} + {1'b0, i_b[DATA_W-1:H]};
    assign w_hi1 = {1'b0, i_a[DATA_W-1:H]} + {1'b0, i_b[DATA_W-1:H]} + {{H{1'b0}}, 1'b1};

    assign o_sum[H-1:0]            = w_lo[H-1:0];
    assign {o_cout, o_sum[DATA_W-1:H]} = w_lo[H] ? w_hi1 : w_hi0;
endmodule

// File: rtl/csa_acc_seq.sv
// rtl/csa_acc_seq.sv - sequential accumulator job engine; CSA_ACC_SAT_EN enables saturation
module csa_acc_seq
    import csa_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    csa_acc_seq_if.slave  bus
);
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_acc;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_xfer;
    logic              w_load;
    logic [DATA_W-1:0] w_sum;
    logic              w_cout;

    csa_16b u_add (
        .i_a    (r_acc),
        .i_b    (bus.in_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = (bus.len != '0) ? ACC : DONE;
                end
            end
            ACC: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (r_cnt == CNT_W'(1))) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_load = (r_state == IDLE) && bus.start;
    assign w_xfer = w_in_ready && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= bus.bias;
            r_ovf <= 1'b0;
            r_cnt <= bus.len;
        end else if (w_xfer) begin
`ifdef CSA_ACC_SAT_EN
            // Once pinned at all-ones every further operand carries out again, so it stays pinned.
            r_acc <= w_cout ? {DATA_W{1'b1}} : w_sum;
`else
            r_acc <= w_sum;
`endif
            r_ovf <= r_ovf | w_cout;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_sum   = r_acc;
    assign bus.out_ovf   = r_ovf;
endmodule

// File: tb/tb_csa_acc_seq.sv
// tb/tb_csa_acc_seq.sv - scoreboard bench for csa_acc_seq against an arithmetic job model
module tb_csa_acc_seq;
    import csa_pkg::*;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
        int          exp_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_acc_seq_if ifc ();
    csa_acc_seq dut (.clk(clk), .rst(rst), .bus(ifc));

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        sbq[$];
    logic [15:0] tb_ops[$];
    bit          tb_gaps[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Job model: plain integer sum of bias and operands, tracking any carry past 16 bits.
    function automatic exp_t model(input logic [15:0] bias, input int exp_cyc);
        exp_t e;
        int   acc;
        int   t;
        acc = int'(bias);
        e.ovf = 1'b0;
        foreach (tb_ops[i]) begin
            t = acc + int'(tb_ops[i]);
            if (t > 65535) begin
                e.ovf = 1'b1;
`ifdef CSA_ACC_SAT_EN
                acc = 65535;
`else
                acc = t - 65536;
`endif
            end else begin
                acc = t;
            end
        end
        e.sum = 16'(acc);
        e.exp_cyc = exp_cyc;
        return e;
    endfunction

    exp_t cur_e;
    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (!rst && ifc.out_valid) begin
            if (!prev_v) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    cur_e = sbq.pop_front();
                    check("out_sum", 32'(ifc.out_sum), 32'(cur_e.sum));
                    check("out_ovf", 32'(ifc.out_ovf), 32'(cur_e.ovf));
                    if (cur_e.exp_cyc >= 0) check("latency", 32'(cyc), 32'(cur_e.exp_cyc));
                end
            end else begin
                check("hold_sum", 32'(ifc.out_sum), 32'(cur_e.sum));
                check("hold_ovf", 32'(ifc.out_ovf), 32'(cur_e.ovf));
            end
        end
        prev_v = ifc.out_valid && !rst;
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        sbq.delete();
        rst = 1'b0;
    endtask

    // gap_mode: 0 = in_valid held high, 1 = random gaps, 2 = pattern from tb_gaps
    task automatic run_job(input int len, input logic [15:0] bias, input int gap_mode,
                           input int out_delay, input bit start_in_done);
        int i;
        int guard;
        logic rdy;
        ifc.start = 1'b1;
        ifc.len   = 8'(len);
        ifc.bias  = bias;
        sbq.push_back(model(bias, (gap_mode == 0) ? cyc + 1 + len : -1));
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.len   = 8'($urandom);
        ifc.bias  = 16'($urandom);
        if (len == 0) begin
            @(negedge clk);
            check("len0_in_ready", 32'(ifc.in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        i = 0;
        guard = 0;
        while (i < len && guard < 4000) begin
            case (gap_mode)
                0: ifc.in_valid = 1'b1;
                1: ifc.in_valid = ($urandom_range(0, 2) != 0);
                default: ifc.in_valid = (tb_gaps.size() != 0) ? tb_gaps.pop_front() : 1'b1;
            endcase
            ifc.in_data = ifc.in_valid ? tb_ops[i] : 16'($urandom);
            @(negedge clk);
            rdy = ifc.in_ready;
            @(posedge clk);
            if (ifc.in_valid && rdy) i++;
            #1;
            guard++;
        end
        ifc.in_valid = 1'b0;
        if (i < len) check("operand_timeout", 32'(i), 32'(len));
        guard = 0;
        while (!ifc.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ifc.out_valid) check("result_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        repeat (out_delay) begin
            ifc.start = start_in_done;
            ifc.len   = 8'd3;
            @(posedge clk);
            #1;
        end
        ifc.start = start_in_done;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        ifc.start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(ifc.busy), 32'd0);
        check("idle_out_valid", 32'(ifc.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        ifc.start = 1'b0;
        ifc.len = '0;
        ifc.bias = '0;
        ifc.in_valid = 1'b0;
        ifc.in_data = '0;
        ifc.out_ready = 1'b0;
        do_reset(3);
        @(negedge clk);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        check("rst_out_sum", 32'(ifc.out_sum), 32'd0);
        check("rst_out_ovf", 32'(ifc.out_ovf), 32'd0);
        @(posedge clk);
        #1;

        tb_ops = '{16'h0001, 16'h0002, 16'h0003};
        run_job(3, 16'h0000, 0, 0, 1'b0);
        tb_ops = '{16'hAA55 ^ 16'hFFFF, 16'h0002};
        tb_ops[0] = 16'h55AA;
        run_job(2, 16'hAA55, 0, 1, 1'b0);
        tb_ops = '{};
        run_job(0, 16'h1234, 0, 0, 1'b0);
        tb_ops = '{16'h1111, 16'h2222};
        tb_gaps = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_job(2, 16'h0100, 2, 3, 1'b1);

        // Abort a job after its first operand.
        ifc.start = 1'b1;
        ifc.len = 8'd4;
        ifc.bias = 16'h1111;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_data = 16'h0001;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(ifc.busy), 32'd0);
        check("abort_out_valid", 32'(ifc.out_valid), 32'd0);
        check("abort_out_sum", 32'(ifc.out_sum), 32'd0);
        check("abort_out_ovf", 32'(ifc.out_ovf), 32'd0);
        @(posedge clk);
        #1;
        tb_ops = '{16'hFF04};
        run_job(1, 16'hAA05, 0, 0, 1'b0);

        tb_ops = '{};
        for (int k = 0; k < 255; k++) tb_ops.push_back(16'($urandom_range(0, 600)));
        run_job(255, 16'($urandom), 0, 0, 1'b0);

        for (int j = 0; j < 40; j++) begin
            len = $urandom_range(0, 7);
            tb_ops = '{};
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) tb_ops.push_back(16'($urandom_range(0, 15)));
                else tb_ops.push_back(16'($urandom));
            end
            run_job(len, 16'($urandom), (j % 3 == 0) ? 0 : 1, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
